// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : uart_pkg                                                  |
// | Purpose  : Shared UART types, frame constants and bit-timing helper. |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package uart_pkg;

  // Serializer FSM states; PARITY is only reachable in parity builds.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_STOP_BITS = 1;

  // Clock cycles per line bit, truncating division (shared with the receiver).
  function automatic int uart_cycles_per_bit(input int clk_hz, input int bit_rate);
    return clk_hz / bit_rate;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : uart_tx_byte                                              |
// | Purpose  : Serializes one byte as start / 8 data (LSB first) /       |
// |            [even parity] / stop. A new byte can be loaded on the     |
// |            last stop cycle so consecutive frames have no gap.        |
// |            Parity frame bit present when UART_TX_PARITY_EN defined.  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int CYCLES_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       ready,
  output logic       txd,
  output logic       done
);

  localparam int              CNT_W    = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [2:0]       BIT_LAST = 3'(UART_DATA_BITS - 1);

  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_q,   bit_d;
  logic             txd_q,   txd_d;
  logic             done_q,  done_d;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic bit_end;
  logic load;

  assign bit_end = (cnt_q == CNT_LAST);
  // Ready in IDLE, and on the final stop cycle so the next byte follows at once.
  assign ready   = (state_q == IDLE) || ((state_q == STOP) && bit_end);
  assign load    = start && ready;
  assign txd     = txd_q;
  assign done    = done_q;

  // Next-state, bit timer and next line level (txd is registered).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    txd_d    = txd_q;
    done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    if (state_q != IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          txd_d   = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            txd_d   = parity_q;
`else
            state_d = STOP;
            txd_d   = 1'b1;
`endif
          end else begin
            shift_d = shift_q >> 1;
            txd_d   = shift_q[1];
            bit_d   = bit_q + 3'd1;
          end
        end
      end
      PARITY: begin
`ifdef UART_TX_PARITY_EN
        if (bit_end) begin
          state_d = STOP;
          txd_d   = 1'b1;
        end
`else
        // Unreachable without parity; recover to idle.
        state_d = IDLE;
        cnt_d   = '0;
        txd_d   = 1'b1;
`endif
      end
      STOP: begin
        if (bit_end) begin
          done_d  = 1'b1;
          state_d = IDLE;
          txd_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        txd_d   = 1'b1;
      end
    endcase

    // Loading a byte overrides the idle/stop outcome above.
    if (load) begin
      state_d  = START;
      cnt_d    = '0;
      shift_d  = data;
      bit_d    = '0;
      txd_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d = ^data;
`endif
    end
  end

  // State registers; reset forces the line idle-high immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      bit_q    <= '0;
      txd_q    <= 1'b1;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      txd_q    <= txd_d;
      done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_word_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : uart_word_tx                                              |
// | Purpose  : Accepts 32-bit words over valid/ready and sends them as   |
// |            WORD_BYTES back-to-back UART frames, LSB byte first.      |
// |            Define UART_TX_PARITY_EN for 11-bit even-parity frames.   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module uart_word_tx
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BIT_RATE   = 9600,
  parameter int WORD_BYTES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_en,
  input  logic        word_valid,
  input  logic [31:0] word_data,
  output logic        word_ready,
  output logic        uart_txd,
  output logic        uart_tx_busy,
  output logic        byte_done
);

  localparam int               CYCLES_PER_BIT = uart_cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam int               IDX_W          = $clog2(WORD_BYTES + 1);
  localparam logic [IDX_W-1:0] IDX_END        = IDX_W'(WORD_BYTES);
  localparam int               LANES          = 32 / UART_DATA_BITS;

  logic [31:0]      word_q,  word_d;
  logic [IDX_W-1:0] idx_q,   idx_d;   // next byte to hand to the serializer
  logic             busy_q,  busy_d;
  logic             ready_q, ready_d;

  logic       accept;
  logic       byte_start;
  logic       byte_ready;
  logic [7:0] byte_data;

  assign accept       = word_valid && ready_q;
  assign byte_start   = busy_q && (idx_q != IDX_END);
  assign word_ready   = ready_q;
  assign uart_tx_busy = busy_q;

  // Select byte idx_q of the latched word; zero once every byte is launched.
  always_comb begin
    byte_data = '0;
    for (int k = 0; k < LANES; k++) begin
      if (idx_q == IDX_W'(k)) begin
        byte_data = word_q[8*k +: 8];
      end
    end
  end

  // Word latch, byte sequencing, busy and the registered ready.
  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    busy_d = busy_q;
    if (accept) begin
      word_d = word_data;
      idx_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q && byte_ready) begin
      if (idx_q != IDX_END) begin
        idx_d = idx_q + IDX_W'(1);
      end else begin
        // Last stop bit completes on this edge.
        idx_d  = '0;
        busy_d = 1'b0;
      end
    end
    // tx_en gates acceptance only; an in-flight word always completes.
    ready_d = tx_en && !busy_d;
  end

  // Handshake and word registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q  <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      word_q  <= word_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  uart_tx_byte #(
    .CYCLES_PER_BIT(CYCLES_PER_BIT)
  ) u_tx_byte (
    .clk   (clk),
    .rst   (rst),
    .start (byte_start),
    .data  (byte_data),
    .ready (byte_ready),
    .txd   (uart_txd),
    .done  (byte_done)
  );

endmodule
`default_nettype wire

// File: doc/uart_word_tx.md
# uart_word_tx

UART transmit engine that serializes 32-bit words as four consecutive 8N1 frames, least-significant byte first, matching the byte order the instruction-loading receiver path expects. It is the transmit counterpart of the wrapper's UART receive/loader. It drives a board TX pin, or loops back into the receiver for self-test. Upstream logic hands it one word at a time over a valid/ready handshake.

## Interface
- `CLK_HZ`, default 50000000: system clock frequency in Hz.
- `BIT_RATE`, default 9600: line bit rate in bits/s.
- `WORD_BYTES`, default 4: bytes per accepted word, sent LSB byte first.
- `clk`, input, 1: system clock; all logic on rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `tx_en`, input, 1: transmit enable; gates acceptance of new words only.
- `word_valid`, input, 1: upstream word available.
- `word_data`, input, 32: word to send.
- `word_ready`, output, 1: block can accept a word this cycle.
- `uart_txd`, output, 1: serial line, idle high.
- `uart_tx_busy`, output, 1: high from the accept cycle until the last stop bit completes.
- `byte_done`, output, 1: one-cycle pulse after each byte's stop bit completes.

## Operation
- `CYCLES_PER_BIT = CLK_HZ / BIT_RATE`, using truncating integer division (5208 at the defaults). The bit-cycle counter is `$clog2(CYCLES_PER_BIT)` wide.
- Reset values: `uart_txd`=1, `word_ready`=0 while `rst` is high, `uart_tx_busy`=0, `byte_done`=0, byte index=0, FSM=IDLE.
- FSM states: IDLE → START → DATA → [PARITY] → STOP → IDLE or START.
  - IDLE: `word_ready = tx_en`. When `word_valid && word_ready`, latch `word_data`, clear the byte index, and go to START.
  - START: drive `uart_txd`=0 for CYCLES_PER_BIT cycles, then go to DATA.
  - DATA: shift out bit 0 first, each bit for CYCLES_PER_BIT cycles; after 8 bits go to PARITY if built in, otherwise STOP.
  - STOP: drive 1 for CYCLES_PER_BIT cycles, then pulse `byte_done`. If byte index < WORD_BYTES-1, increment it and go to START. Otherwise go to IDLE.
- Byte k is `word[8k+7:8k]`, so `32'hfe010113` goes out as 0x13, 0x01, 0x01, 0xfe.
- Deasserting `tx_en` mid-word does not abort. The in-flight word completes, and no new word is accepted.
- `word_data` is sampled only on the accept edge; later changes are ignored.
- Asserting `rst` mid-frame forces `uart_txd`=1 immediately, the truncated frame is discarded, and there is no resume.

## Timing
- Accept at edge N: `uart_txd` falls to 0 after edge N+1 (one-cycle latency), and `uart_tx_busy` rises after edge N.
- Each frame is 10·CYCLES_PER_BIT cycles (11· with parity). Bytes within a word are back-to-back with zero idle gap.
- The last STOP ends and `byte_done` pulses. FSM returns to IDLE and `word_ready` reasserts on the next edge. If `word_valid` is held, the next word is accepted on that edge, giving at most 2 extra idle-high cycles between words.
- `word_ready` and `uart_txd` are registered outputs. The handshake has no combinational input-to-output path.

## Configuration
- `UART_TX_PARITY_EN` defined: a PARITY state is inserted after DATA. It sends even parity (XOR of the 8 data bits) for CYCLES_PER_BIT cycles, and each frame becomes 11 bits.
- `UART_TX_PARITY_EN` undefined: no PARITY state and no parity logic; frames are 8N1, 10 bits.

## Structure
- Package `uart_pkg` holds:
  - the FSM state typedef (IDLE/START/DATA/PARITY/STOP);
  - `UART_DATA_BITS`=8 and `UART_STOP_BITS`=1;
  - a function that computes CYCLES_PER_BIT from CLK_HZ and BIT_RATE (shared with the receiver).
- Sub-module `uart_tx_byte` serializes one byte using the bit timer and FSM, with a start/done handshake. `uart_word_tx` holds the word latch, byte index, handshake and `uart_tx_busy`.

## Test plan
Use CLK_HZ=1000 and BIT_RATE=100 (CYCLES_PER_BIT=10) unless noted.
- Reset: hold `rst` high with `tx_en`=1 → `uart_txd`=1, `word_ready`=0, `uart_tx_busy`=0. After release, `word_ready`=1 on the next edge.
- Single word: send `32'hfe010113` → line carries bytes 0x13, 0x01, 0x01, 0xfe, each as start/LSB-first/stop. There are 4 `byte_done` pulses, and `uart_tx_busy` stays high for 400 cycles ±1.
- Loopback at defaults: feed `uart_txd` into the existing receiver wrapper and send `32'h00812e23` → the receiver reports 0x23, 0x2e, 0x81, 0x00 in order.
- Enable gating: `word_valid`=1 with `tx_en`=0 for 50 cycles → no accept and `uart_txd` stays 1. Raise `tx_en` → accept on the next edge and the start bit follows one cycle later.
- Reset mid-word: assert `rst` during byte 2's DATA state → `uart_txd`=1 within the same cycle and `uart_tx_busy`=0. After release the next word starts from byte 0.
- Parity build (`UART_TX_PARITY_EN`): send `32'h00000013` → first frame is 11 bits with parity=1. The 0x00 frames carry parity 0, and the total is 440 cycles.
